uart_cmd_ctrl: RTL and testbench
================================

# uart_cmd_ctrl

Register-access command controller that sits directly downstream of the UART block. It pops received bytes from the UART receive FIFO, parses a 2- or 3-byte command protocol, and updates or reads a small internal register file. It pushes one reply byte per command into the UART transmit FIFO. Register 0 is exported so a host on the serial line can drive board outputs (LEDs).

## Interface
Parameters:
- ADDR_W, 4, register address width; register file has 2**ADDR_W 8-bit entries
- TIMEOUT, 50000, clk cycles allowed between consecutive bytes of one command before it is aborted (≥2)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- r_data  in  8  head byte of UART receive FIFO, valid while rx_empty=0
- rx_empty  in  1  receive FIFO empty flag
- rd_uart  out  1  one-cycle pop strobe to receive FIFO
- w_data  out  8  reply byte to UART transmit FIFO
- wr_uart  out  1  one-cycle push strobe to transmit FIFO
- tx_full  in  1  transmit FIFO full flag
- reg0_out  out  8  current content of register 0
- busy  out  1  high whenever state ≠ IDLE

## Operation
- Protocol bytes:
  - write: 'W'(0x57), addr, data → reply 'K'(0x4B)
  - read: 'R'(0x52), addr → reply reg[addr]
  - any other first byte → reply '?'(0x3F)
- Address byte:
  - bits [ADDR_W-1:0] select the register
  - if any bit above ADDR_W-1 is set, the command completes its byte sequence and replies '?' with no register write.
- FSM states and transitions:
  - IDLE: wait for a command byte; on pop, latch the command.
    - 'W' or 'R' → GET_ADDR
    - else → SEND with reply '?'
  - GET_ADDR: on pop, latch the address.
    - write → GET_DATA
    - read → SEND with reply reg[addr], or '?' if the address is out of range
  - GET_DATA: on pop, write the data byte to reg[addr] if the address is in range, then go to SEND with reply 'K' or '?'.
  - SEND: hold the reply on w_data; when tx_full=0, pulse wr_uart and go to IDLE.
- Byte consumption: in IDLE/GET_ADDR/GET_DATA, if rx_empty=0 then rd_uart=1 that same cycle and r_data is sampled on that edge. rd_uart is never asserted in SEND or while rx_empty=1.
- Timeout counter:
  - cleared on every pop; increments each cycle in GET_ADDR/GET_DATA while rx_empty=1
  - reaching TIMEOUT-1 returns the FSM to IDLE with no reply and no register write
  - width is $clog2(TIMEOUT)
- Reset:
  - state IDLE, all registers 0, counter 0
  - rd_uart=0, wr_uart=0, w_data=0x00, reg0_out=0x00, busy=0
  - reset mid-command discards the partial command; an undelivered reply is lost.

## Timing
- Throughput: at most one byte popped per cycle; no idle cycles are required between bytes of one command.
- Write effect: the register updates on the edge that pops the data byte and is visible (including on reg0_out) on the next cycle.
- Read data: sampled from the register file on the edge that pops the address byte.
- Reply latency: wr_uart pulses on the first cycle in SEND with tx_full=0, i.e. 1 cycle after the final pop when the TX FIFO is not full. Minimum command-to-command spacing: W = 4 cycles, R = 3 cycles.
- SEND with tx_full=1: w_data is held stable and wr_uart stays 0 indefinitely (no timeout in SEND); incoming RX bytes stay queued in the FIFO.
- wr_uart and rd_uart are never high in the same cycle.
- Timeout boundary: a byte arriving (rx_empty falls) in the same cycle the counter reaches TIMEOUT-1 is popped, and the abort does not occur.

## Test plan
- Reset with reset=1 mid-stream → all outputs 0, busy=0; after release, reg0_out=0x00.
- RX FIFO preloaded with 0x57,0x00,0xA5 → three consecutive rd_uart pulses; reg0_out=0xA5 on the cycle after the third pop; one wr_uart with w_data=0x4B.
- Write 0x3C to addr 5, then send 0x52,0x05 → reply 0x3C; then send 0x52,0x15 (out of range) → reply 0x3F with no register change.
- Byte 0x41 → single pop, reply 0x3F, busy back to 0 after the push.
- TIMEOUT=8: send 0x57,0x02 then nothing → after 7 empty cycles FSM returns to IDLE, no wr_uart; a subsequent 0x52,0x02 → reply 0x00.
- tx_full held at 1 during the reply of 0x52,0x00 → w_data stable and wr_uart=0 for 20 cycles, no pops; release tx_full → exactly one wr_uart.

Source files
------------

// File: rtl/uart_cmd_ctrl.sv
// Register-access command controller behind a UART: parses 'W' addr data / 'R' addr
// commands from the RX FIFO, updates a small register file and pushes one reply byte.
module uart_cmd_ctrl #(
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] r_data,
  input  logic       rx_empty,
  output logic       rd_uart,
  output logic [7:0] w_data,
  output logic       wr_uart,
  input  logic       tx_full,
  output logic [7:0] reg0_out,
  output logic       busy
);

  localparam int                CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [7:0]        CH_W     = 8'h57;
  localparam logic [7:0]        CH_R     = 8'h52;
  localparam logic [7:0]        CH_K     = 8'h4B;
  localparam logic [7:0]        CH_Q     = 8'h3F;

  typedef enum logic [1:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    SEND
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_is_write;
  logic [ADDR_W-1:0] r_addr;
  logic              r_addr_ok;
  logic [7:0]        r_reply;
  logic [CNT_W-1:0]  r_cnt;
  logic [7:0]        r_regs [2**ADDR_W];

  logic              w_pop;
  logic              w_push;
  logic              w_reg_we;
  logic              w_reply_load;
  logic [7:0]        w_reply_next;
  logic [CNT_W-1:0]  w_cnt_next;
  logic              w_byte_ok;

  // An address byte is only usable if nothing is set above the register-select bits.
  assign w_byte_ok = ((r_data >> ADDR_W) == 8'h00);

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_push       = 1'b0;
    w_reg_we     = 1'b0;
    w_reply_load = 1'b0;
    w_reply_next = r_reply;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (!rx_empty) begin
          w_pop      = 1'b1;
          w_cnt_next = '0;
          if (r_data == CH_W || r_data == CH_R) begin
            w_state_next = GET_ADDR;
          end else begin
            w_state_next = SEND;
            w_reply_load = 1'b1;
            w_reply_next = CH_Q;
          end
        end
      end
      GET_ADDR: begin
        if (!rx_empty) begin
          w_pop      = 1'b1;
          w_cnt_next = '0;
          if (r_is_write) begin
            w_state_next = GET_DATA;
          end else begin
            w_state_next = SEND;
            w_reply_load = 1'b1;
            w_reply_next = w_byte_ok ? r_regs[r_data[ADDR_W-1:0]] : CH_Q;
          end
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      GET_DATA: begin
        if (!rx_empty) begin
          w_pop        = 1'b1;
          w_cnt_next   = '0;
          w_reg_we     = r_addr_ok;
          w_state_next = SEND;
          w_reply_load = 1'b1;
          w_reply_next = r_addr_ok ? CH_K : CH_Q;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      SEND: begin
        if (!tx_full) begin
          w_push       = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_is_write <= 1'b0;
      r_addr     <= '0;
      r_addr_ok  <= 1'b0;
      r_reply    <= '0;
      r_cnt      <= '0;
      for (int i = 0; i < 2**ADDR_W; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_reply_load) begin
        r_reply <= w_reply_next;
      end
      if (w_pop && r_state == IDLE) begin
        r_is_write <= (r_data == CH_W);
      end
      if (w_pop && r_state == GET_ADDR) begin
        r_addr    <= r_data[ADDR_W-1:0];
        r_addr_ok <= w_byte_ok;
      end
      if (w_reg_we) begin
        r_regs[r_addr] <= r_data;
      end
    end
  end

  assign rd_uart  = w_pop;
  assign wr_uart  = w_push;
  assign w_data   = r_reply;
  assign reg0_out = r_regs[0];
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed self-checking bench for uart_cmd_ctrl with a modelled RX FIFO and a TX log.
module tb_uart_cmd_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] r_data = 8'h00;
  logic       rx_empty = 1'b1;
  logic       rd_uart;
  logic [7:0] w_data;
  logic       wr_uart;
  logic       tx_full = 1'b0;
  logic [7:0] reg0_out;
  logic       busy;

  int checks = 0;
  int failures = 0;

  logic [7:0] rxMem [0:255];
  int         rxWr = 0;
  int         rxRd = 0;
  logic [7:0] txLog [0:255];
  int         pushCount = 0;
  int         popCount = 0;
  int         bothHigh = 0;

  uart_cmd_ctrl #(.ADDR_W(4), .TIMEOUT(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .r_data   (r_data),
    .rx_empty (rx_empty),
    .rd_uart  (rd_uart),
    .w_data   (w_data),
    .wr_uart  (wr_uart),
    .tx_full  (tx_full),
    .reg0_out (reg0_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // RX FIFO and TX FIFO side of the UART: pops/pushes are observed on the active edge.
  always @(posedge clk) begin
    if (rd_uart) begin
      rxRd     <= rxRd + 1;
      popCount <= popCount + 1;
    end
    if (wr_uart) begin
      txLog[pushCount[7:0]] <= w_data;
      pushCount <= pushCount + 1;
    end
    if (rd_uart && wr_uart) bothHigh <= bothHigh + 1;
  end

  always @(negedge clk) begin
    rx_empty = (rxRd == rxWr);
    r_data   = (rxRd == rxWr) ? 8'h00 : rxMem[rxRd[7:0]];
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pushRx(input logic [7:0] b);
    rxMem[rxWr[7:0]] = b;
    rxWr = rxWr + 1;
  endtask

  task automatic sendCmd(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input int n, output logic got, output logic [7:0] reply);
    int start;
    start = pushCount;
    pushRx(b0);
    if (n > 1) pushRx(b1);
    if (n > 2) pushRx(b2);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      cycles(1);
      if (pushCount != start) got = 1'b1;
    end
    reply = got ? txLog[start[7:0]] : 8'h00;
  endtask

  task automatic test_reset;
    logic       got;
    logic [7:0] rep;
    reset = 1'b1;
    cycles(2);
    checks++;
    if ({rd_uart, wr_uart, w_data, reg0_out, busy} !== 19'h0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got rd=%b wr=%b w_data=%h reg0=%h busy=%b, want all 0",
               rd_uart, wr_uart, w_data, reg0_out, busy);
    end
    reset = 1'b0;
    cycles(1);
    sendCmd(8'h57, 8'h00, 8'h11, 3, got, rep);
    checks++;
    if (!got || rep !== 8'h4B) begin
      failures++;
      $display("[TB] FAIL reset_prewrite_reply: got=%b reply=%h, want 4b", got, rep);
    end
    checks++;
    if (reg0_out !== 8'h11) begin
      failures++;
      $display("[TB] FAIL reset_prewrite_reg0: got %h, want 11", reg0_out);
    end
    pushRx(8'h57);
    pushRx(8'h00);
    cycles(3);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_midcmd_busy: got %b, want 1", busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({rd_uart, wr_uart, w_data, reg0_out, busy} !== 19'h0) begin
      failures++;
      $display("[TB] FAIL reset_midcmd_outputs: got rd=%b wr=%b w_data=%h reg0=%h busy=%b, want all 0",
               rd_uart, wr_uart, w_data, reg0_out, busy);
    end
    cycles(1);
    reset = 1'b0;
    cycles(2);
    checks++;
    if (reg0_out !== 8'h00 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_release: got reg0=%h busy=%b, want 00/0", reg0_out, busy);
    end
  endtask

  task automatic test_write_reg0;
    int p0;
    int t0;
    p0 = popCount;
    t0 = pushCount;
    pushRx(8'h57);
    pushRx(8'h00);
    pushRx(8'hA5);
    for (int i = 1; i <= 3; i++) begin
      cycles(1);
      checks++;
      if (popCount - p0 !== i) begin
        failures++;
        $display("[TB] FAIL write_pop_%0d: got %0d pops, want %0d", i, popCount - p0, i);
      end
    end
    checks++;
    if (reg0_out !== 8'hA5 || wr_uart !== 1'b1 || w_data !== 8'h4B) begin
      failures++;
      $display("[TB] FAIL write_after_third_pop: got reg0=%h wr=%b w_data=%h, want a5/1/4b",
               reg0_out, wr_uart, w_data);
    end
    cycles(1);
    checks++;
    if (pushCount - t0 !== 1 || txLog[t0[7:0]] !== 8'h4B || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL write_reply: got pushes=%0d byte=%h busy=%b, want 1/4b/0",
               pushCount - t0, txLog[t0[7:0]], busy);
    end
  endtask

  task automatic test_read_back;
    logic       got;
    logic [7:0] rep;
    sendCmd(8'h57, 8'h05, 8'h3C, 3, got, rep);
    checks++;
    if (!got || rep !== 8'h4B) begin
      failures++;
      $display("[TB] FAIL rd_write5: got=%b reply=%h, want 4b", got, rep);
    end
    sendCmd(8'h52, 8'h05, 8'h00, 2, got, rep);
    checks++;
    if (!got || rep !== 8'h3C) begin
      failures++;
      $display("[TB] FAIL rd_read5: got=%b reply=%h, want 3c", got, rep);
    end
    sendCmd(8'h52, 8'h15, 8'h00, 2, got, rep);
    checks++;
    if (!got || rep !== 8'h3F) begin
      failures++;
      $display("[TB] FAIL rd_read_oor: got=%b reply=%h, want 3f", got, rep);
    end
    sendCmd(8'h57, 8'h15, 8'h77, 3, got, rep);
    checks++;
    if (!got || rep !== 8'h3F) begin
      failures++;
      $display("[TB] FAIL rd_write_oor: got=%b reply=%h, want 3f", got, rep);
    end
    sendCmd(8'h52, 8'h05, 8'h00, 2, got, rep);
    checks++;
    if (!got || rep !== 8'h3C) begin
      failures++;
      $display("[TB] FAIL rd_read5_after_oor: got=%b reply=%h, want 3c", got, rep);
    end
    sendCmd(8'h52, 8'h00, 8'h00, 2, got, rep);
    checks++;
    if (!got || rep !== 8'hA5) begin
      failures++;
      $display("[TB] FAIL rd_read0: got=%b reply=%h, want a5", got, rep);
    end
  endtask

  task automatic test_bad_cmd;
    int p0;
    int t0;
    p0 = popCount;
    t0 = pushCount;
    pushRx(8'h41);
    cycles(1);
    checks++;
    if (popCount - p0 !== 1 || busy !== 1'b1 || w_data !== 8'h3F || wr_uart !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bad_send: got pops=%0d busy=%b w_data=%h wr=%b, want 1/1/3f/1",
               popCount - p0, busy, w_data, wr_uart);
    end
    cycles(1);
    checks++;
    if (pushCount - t0 !== 1 || popCount - p0 !== 1 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bad_done: got pushes=%0d pops=%0d busy=%b, want 1/1/0",
               pushCount - t0, popCount - p0, busy);
    end
  endtask

  task automatic test_timeout;
    int         p0;
    int         t0;
    logic       got;
    logic [7:0] rep;
    p0 = popCount;
    t0 = pushCount;
    pushRx(8'h57);
    pushRx(8'h02);
    cycles(10);
    checks++;
    if (busy !== 1'b0 || pushCount != t0 || popCount - p0 !== 2) begin
      failures++;
      $display("[TB] FAIL timeout_abort: got busy=%b pushes=%0d pops=%0d, want 0/0/2",
               busy, pushCount - t0, popCount - p0);
    end
    sendCmd(8'h52, 8'h02, 8'h00, 2, got, rep);
    checks++;
    if (!got || rep !== 8'h00) begin
      failures++;
      $display("[TB] FAIL timeout_read2: got=%b reply=%h, want 00", got, rep);
    end
    t0 = pushCount;
    pushRx(8'h57);
    pushRx(8'h03);
    cycles(9);
    pushRx(8'h66);
    cycles(2);
    checks++;
    if (pushCount - t0 !== 1 || txLog[t0[7:0]] !== 8'h4B) begin
      failures++;
      $display("[TB] FAIL timeout_boundary: got pushes=%0d byte=%h, want 1/4b",
               pushCount - t0, txLog[t0[7:0]]);
    end
    sendCmd(8'h52, 8'h03, 8'h00, 2, got, rep);
    checks++;
    if (!got || rep !== 8'h66) begin
      failures++;
      $display("[TB] FAIL timeout_read3: got=%b reply=%h, want 66", got, rep);
    end
  endtask

  task automatic test_tx_full;
    int p0;
    int t0;
    int bad;
    p0 = popCount;
    t0 = pushCount;
    tx_full = 1'b1;
    pushRx(8'h52);
    pushRx(8'h00);
    cycles(2);
    pushRx(8'h41);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cycles(1);
      if (w_data !== 8'hA5 || wr_uart !== 1'b0 || popCount - p0 !== 2) bad++;
    end
    checks++;
    if (bad != 0 || pushCount != t0) begin
      failures++;
      $display("[TB] FAIL txfull_stall: got %0d bad cycles, pushes=%0d, want 0/0", bad, pushCount - t0);
    end
    tx_full = 1'b0;
    cycles(1);
    checks++;
    if (pushCount - t0 !== 1 || txLog[t0[7:0]] !== 8'hA5) begin
      failures++;
      $display("[TB] FAIL txfull_release: got pushes=%0d byte=%h, want 1/a5",
               pushCount - t0, txLog[t0[7:0]]);
    end
    cycles(2);
    checks++;
    if (pushCount - t0 !== 2 || txLog[(t0 + 1) & 255] !== 8'h3F || popCount - p0 !== 3) begin
      failures++;
      $display("[TB] FAIL txfull_queued: got pushes=%0d byte=%h pops=%0d, want 2/3f/3",
               pushCount - t0, txLog[(t0 + 1) & 255], popCount - p0);
    end
  endtask

  task automatic test_back_to_back;
    int p0;
    int t0;
    p0 = popCount;
    t0 = pushCount;
    pushRx(8'h57);
    pushRx(8'h06);
    pushRx(8'h5A);
    pushRx(8'h52);
    pushRx(8'h06);
    cycles(7);
    checks++;
    if (pushCount - t0 !== 2 || popCount - p0 !== 5 ||
        txLog[t0[7:0]] !== 8'h4B || txLog[(t0 + 1) & 255] !== 8'h5A) begin
      failures++;
      $display("[TB] FAIL b2b: got pushes=%0d pops=%0d bytes=%h,%h, want 2/5/4b,5a",
               pushCount - t0, popCount - p0, txLog[t0[7:0]], txLog[(t0 + 1) & 255]);
    end
    checks++;
    if (bothHigh != 0) begin
      failures++;
      $display("[TB] FAIL rd_wr_overlap: got %0d cycles, want 0", bothHigh);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_write_reg0();
    test_read_back();
    test_bad_cmd();
    test_timeout();
    test_tx_full();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
